// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshake and the FIFO write port for the
// write-side arbiter. Clock and reset are kept off the interface.
//
// Signals:
//   req_valid [NREQ]        per-requester data valid
//   req_data  [NREQ*DSIZE]  flattened request data, requester i at [i*DSIZE +: DSIZE]
//   req_ready [NREQ]        per-requester accept
//   wfull                   FIFO full flag (wclk domain)
//   winc                    FIFO write strobe
//   wdata     [DSIZE]       FIFO write data
//   gnt_valid               a grant is currently held
//   gnt_id    [IDW]         index of the granted requester
//
// Modports:
//   master : producers + FIFO side (drives requests and wfull)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  gnt_valid;
   logic [IDW-1:0]        gnt_id;

   modport master (
      output req_valid, req_data, wfull,
      input  req_ready, winc, wdata, gnt_valid, gnt_id
   );

   modport slave (
      input  req_valid, req_data, wfull,
      output req_ready, winc, wdata, gnt_valid, gnt_id
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the dual-clock FIFO among NREQ producers
// in the wclk domain. Round-robin arbitration, at most MAX_BURST beats per
// grant, one IDLE bubble between grants. Never strobes winc while wfull.
//
// Ports:
//   wclk        write-domain clock
//   wrst_n      asynchronous active-low reset
//   arb_en      arbitration enable
//   bus         fifo_wr_arbiter_if.slave (requests, FIFO write port, grant)
//   beat_count  [NREQ*16] accepted beats per requester, saturating
//               (only with FIFO_ARB_STATS_EN)
//   stall_count [16] BURST cycles stalled by wfull with data pending,
//               saturating (only with FIFO_ARB_STATS_EN)
//
// Build option: define FIFO_ARB_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DSIZE     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             arb_en,
   fifo_wr_arbiter_if.slave bus
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0] beat_count,
   output logic [15:0]        stall_count
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int BCW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [IDW-1:0] r_gntId;
   logic [IDW-1:0] r_rrPtr;
   logic [BCW-1:0] r_beatCnt;

   logic [IDW-1:0] w_pickId;
   logic           w_pickFound;
   logic [IDW:0]   w_cand;
   logic [IDW-1:0] w_rrNext;
   logic           w_reqSel;
   logic           w_beat;
   logic           w_lastBeat;
   logic           w_exit;

   // Round-robin search starting at r_rrPtr. The candidate index is one bit
   // wider so the wrap also works when NREQ is not a power of two.
   always_comb begin
      w_pickFound = 1'b0;
      w_pickId    = '0;
      w_cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = {1'b0, r_rrPtr} + (IDW+1)'(k);
         if (w_cand >= (IDW+1)'(NREQ)) begin
            w_cand = w_cand - (IDW+1)'(NREQ);
         end
         if (!w_pickFound && bus.req_valid[w_cand[IDW-1:0]]) begin
            w_pickFound = 1'b1;
            w_pickId    = w_cand[IDW-1:0];
         end
      end
   end

   // Burst bookkeeping: a beat is a real write; the grant is released on the
   // last allowed beat, when the owner has nothing to send, or when
   // arbitration is disabled (a beat in that same cycle still goes through).
   assign w_reqSel   = bus.req_valid[r_gntId];
   assign w_beat     = (r_state == BURST) && w_reqSel && !bus.wfull;
   assign w_lastBeat = w_beat && (r_beatCnt == BCW'(MAX_BURST - 1));
   assign w_exit     = (r_state == BURST) && (w_lastBeat || !w_reqSel || !arb_en);
   assign w_rrNext   = (r_gntId == IDW'(NREQ - 1)) ? '0 : r_gntId + 1'b1;

   // State register.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (arb_en && w_pickFound) w_nextState = BURST;
         BURST:   if (w_exit)                w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Grant, pointer and beat counter. The counter holds while wfull stalls.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_gntId   <= '0;
         r_rrPtr   <= '0;
         r_beatCnt <= '0;
      end else if (r_state == IDLE) begin
         if (arb_en && w_pickFound) begin
            r_gntId   <= w_pickId;
            r_beatCnt <= '0;
         end
      end else begin
         if (w_beat) begin
            r_beatCnt <= r_beatCnt + 1'b1;
         end
         if (w_exit) begin
            r_rrPtr <= w_rrNext;
         end
      end
   end

   // Outputs: everything is quiet in IDLE; in BURST only the owner sees ready.
   always_comb begin
      bus.winc      = 1'b0;
      bus.req_ready = '0;
      bus.wdata     = '0;
      bus.gnt_valid = 1'b0;
      bus.gnt_id    = r_gntId;
      if (r_state == BURST) begin
         bus.gnt_valid          = 1'b1;
         bus.wdata              = bus.req_data[r_gntId*DSIZE +: DSIZE];
         bus.req_ready[r_gntId] = !bus.wfull;
         bus.winc               = w_beat;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] r_beatCount [NREQ];
   logic [15:0] r_stallCount;

   // Saturating per-requester beat counters and the shared stall counter.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            r_beatCount[i] <= '0;
         end
         r_stallCount <= '0;
      end else begin
         if (w_beat && (r_beatCount[r_gntId] != 16'hFFFF)) begin
            r_beatCount[r_gntId] <= r_beatCount[r_gntId] + 16'd1;
         end
         if ((r_state == BURST) && bus.wfull && w_reqSel && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_beatOut
      assign beat_count[g*16 +: 16] = r_beatCount[g];
   end
   assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4).
// A transaction-level reference model predicts grant, strobe, data and
// ready every cycle; directed scenarios add fixed expectations on top.
// Define FIFO_ARB_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DSIZE     = 8;
   localparam int MAX_BURST = 4;
   localparam int IDW       = $clog2(NREQ);
   localparam int VW        = 2 + IDW + NREQ + DSIZE;

   logic wclk;
   logic wrst_n;
   logic arbEn;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

`ifdef FIFO_ARB_STATS_EN
   logic [NREQ*16-1:0] beatCount;
   logic [15:0]        stallCount;
`endif

   fifo_wr_arbiter #(
      .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)
   ) dut (
      .wclk(wclk),
      .wrst_n(wrst_n),
      .arb_en(arbEn),
      .bus(bus)
`ifdef FIFO_ARB_STATS_EN
      ,
      .beat_count(beatCount),
      .stall_count(stallCount)
`endif
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int total = 0;
   int bad   = 0;

   // Producer sources: words left to send, the word currently presented,
   // and whether a presented word is still waiting to be accepted.
   int               srcLeft  [NREQ];
   logic [DSIZE-1:0] srcNext  [NREQ];
   bit               hold     [NREQ];
   int               accepted [NREQ];
   int               gapPct;
   bit               randData;

   // Reference model: who owns the port, beats taken, next search start.
   bit mBusy;
   int mGnt, mBeats, mRr, mStall;
   int mTot [NREQ];

   logic [VW-1:0] expVec, actVec;

   task automatic modelReset();
      mBusy = 0; mGnt = 0; mBeats = 0; mRr = 0; mStall = 0;
      for (int i = 0; i < NREQ; i++) mTot[i] = 0;
   endtask

   task automatic predict();
      logic [NREQ-1:0]  rdy;
      logic [DSIZE-1:0] dat;
      logic             w;
      logic [IDW-1:0]   id;
      rdy = '0; dat = '0; w = 1'b0;
      id  = mGnt[IDW-1:0];
      if (mBusy) begin
         if (!bus.wfull) rdy[mGnt] = 1'b1;
         dat = bus.req_data[mGnt*DSIZE +: DSIZE];
         w   = bus.req_valid[mGnt] && !bus.wfull;
      end
      expVec = {w, mBusy, id, rdy, dat};
      actVec = {bus.winc, bus.gnt_valid, bus.gnt_id, bus.req_ready, bus.wdata};
   endtask

   task automatic advance();
      bit w;
      if (mBusy) begin
         w = bus.req_valid[mGnt] && !bus.wfull;
         if (w) begin
            mBeats++;
            mTot[mGnt]++;
         end
         if (bus.wfull && bus.req_valid[mGnt]) mStall++;
         if ((w && mBeats == MAX_BURST) || !bus.req_valid[mGnt] || !arbEn) begin
            mBusy = 0;
            mRr   = (mGnt + 1) % NREQ;
         end
      end else if (arbEn && (bus.req_valid != '0)) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(mRr + k) % NREQ]) mGnt = (mRr + k) % NREQ;
         end
         mBusy  = 1;
         mBeats = 0;
      end
   endtask

   task automatic applyReqs();
      bit pass;
      for (int i = 0; i < NREQ; i++) begin
         pass = (gapPct == 0) || ($urandom_range(0, 99) >= gapPct);
         bus.req_valid[i] = (srcLeft[i] > 0) && (hold[i] || pass);
         bus.req_data[i*DSIZE +: DSIZE] = srcNext[i];
      end
   endtask

   task automatic consume();
      logic [31:0] r;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            srcLeft[i]--;
            accepted[i]++;
            hold[i] = 0;
            r = $urandom;
            srcNext[i] = randData ? r[DSIZE-1:0] : srcNext[i] + 1'b1;
         end else begin
            hold[i] = bus.req_valid[i];
         end
      end
   endtask

   // Drive one cycle's inputs at the falling edge and sample 2ns later.
   task automatic oneCycle(input logic en, input logic full);
      @(negedge wclk);
      arbEn     = en;
      bus.wfull = full;
      applyReqs();
      #2;
      predict();
   endtask

   task automatic endCycle();
      advance();
      consume();
   endtask

   task automatic doReset();
      @(negedge wclk);
      wrst_n = 1'b0;
      arbEn = 1'b0; bus.wfull = 1'b0; bus.req_valid = '0; bus.req_data = '0;
      gapPct = 0; randData = 0;
      for (int i = 0; i < NREQ; i++) begin
         srcLeft[i] = 0; srcNext[i] = '0; hold[i] = 0; accepted[i] = 0;
      end
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_reset();
      wrst_n = 1'b0;
      arbEn = 1'b1; bus.wfull = 1'b0; bus.req_valid = '1; bus.req_data = '1;
      repeat (3) @(negedge wclk);
      #2;
      total++;
      if ({bus.winc, bus.gnt_valid, bus.gnt_id, bus.req_ready, bus.wdata} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {bus.winc, bus.gnt_valid, bus.gnt_id, bus.req_ready, bus.wdata});
      end
      doReset();
   endtask

   task automatic test_single();
      doReset();
      srcLeft[2] = 3; srcNext[2] = 8'h01;
      for (int c = 0; c < 8; c++) begin
         if (c == 5) begin
            srcLeft[0] = 1; srcLeft[3] = 1;
         end
         oneCycle(1'b1, 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL single_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         if (c >= 1 && c <= 3) begin
            total++;
            if ({bus.winc, bus.gnt_id, bus.wdata} !== {1'b1, IDW'(2), DSIZE'(c)}) begin
               bad++;
               $display("[TB] FAIL single_beat c=%0d: got %h expected %h", c,
                        {bus.winc, bus.gnt_id, bus.wdata}, {1'b1, IDW'(2), DSIZE'(c)});
            end
         end
         if (c == 6) begin
            total++;
            if ({bus.gnt_valid, bus.gnt_id} !== {1'b1, IDW'(3)}) begin
               bad++;
               $display("[TB] FAIL single_rr_next: got %h expected %h",
                        {bus.gnt_valid, bus.gnt_id}, {1'b1, IDW'(3)});
            end
         end
         endCycle();
      end
   endtask

   task automatic test_all_valid();
      logic expW;
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         srcLeft[i] = 50; srcNext[i] = DSIZE'(i * 16);
      end
      for (int c = 0; c < 25; c++) begin
         oneCycle(1'b1, 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL all_valid_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         expW = ((c % 5) != 0);
         total++;
         if (bus.winc !== expW || (expW && bus.gnt_id !== IDW'((c / 5) % NREQ))) begin
            bad++;
            $display("[TB] FAIL all_valid_rotation c=%0d: winc=%b id=%0d expected winc=%b id=%0d",
                     c, bus.winc, bus.gnt_id, expW, (c / 5) % NREQ);
         end
         endCycle();
      end
   endtask

   task automatic test_wfull_stall();
      logic [8:0] pat;
      pat = 9'b011000110;
      doReset();
      srcLeft[1] = 6; srcNext[1] = 8'h40;
      for (int c = 0; c < 9; c++) begin
         oneCycle(1'b1, (c >= 3 && c <= 5));
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL stall_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         total++;
         if (bus.winc !== pat[c] || (c >= 1 && c <= 7 && bus.gnt_id !== IDW'(1))) begin
            bad++;
            $display("[TB] FAIL stall_pattern c=%0d: winc=%b id=%0d expected winc=%b id=1",
                     c, bus.winc, bus.gnt_id, pat[c]);
         end
         endCycle();
      end
   endtask

   task automatic test_drop_valid();
      doReset();
      srcLeft[0] = 2; srcNext[0] = 8'hA0;
      srcLeft[3] = 4; srcNext[3] = 8'hB0;
      for (int c = 0; c < 7; c++) begin
         oneCycle(1'b1, 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL drop_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         if (c == 4 || c == 5) begin
            total++;
            if ({bus.gnt_valid, bus.gnt_id} !== ((c == 4) ? {1'b0, IDW'(0)} : {1'b1, IDW'(3)})) begin
               bad++;
               $display("[TB] FAIL drop_handover c=%0d: got gv=%b id=%0d", c, bus.gnt_valid, bus.gnt_id);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         srcLeft[i] = 50; srcNext[i] = DSIZE'(i + 8'h60);
      end
      for (int c = 0; c < 8; c++) begin
         oneCycle(1'b1, 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL rstmid_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         endCycle();
      end
      @(negedge wclk);
      applyReqs();
      #2;
      wrst_n = 1'b0;
      #1;
      total++;
      if ({bus.winc, bus.gnt_valid, bus.req_ready} !== '0) begin
         bad++;
         $display("[TB] FAIL rstmid_async: got %h expected 0", {bus.winc, bus.gnt_valid, bus.req_ready});
      end
      bus.req_valid = '0;
      @(negedge wclk);
      wrst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) hold[i] = 0;
      modelReset();
      for (int c = 0; c < 3; c++) begin
         oneCycle(1'b1, 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL rstmid_after c=%0d: got %h expected %h", c, actVec, expVec);
         end
         if (c == 1) begin
            total++;
            if ({bus.gnt_valid, bus.gnt_id} !== {1'b1, IDW'(0)}) begin
               bad++;
               $display("[TB] FAIL rstmid_restart: got gv=%b id=%0d expected gv=1 id=0",
                        bus.gnt_valid, bus.gnt_id);
            end
         end
         endCycle();
      end
   endtask

   task automatic test_arb_en_drop();
      doReset();
      srcLeft[0] = 10; srcNext[0] = 8'h10;
      srcLeft[2] = 10; srcNext[2] = 8'h20;
      for (int c = 0; c < 10; c++) begin
         oneCycle(!(c >= 2 && c <= 6), 1'b0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL arben_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         if (c == 2 || (c >= 3 && c <= 6) || c == 8) begin
            total++;
            if ((c == 2 && {bus.winc, bus.gnt_id} !== {1'b1, IDW'(0)}) ||
                (c >= 3 && c <= 6 && {bus.winc, bus.gnt_valid} !== 2'b00) ||
                (c == 8 && {bus.gnt_valid, bus.gnt_id} !== {1'b1, IDW'(2)})) begin
               bad++;
               $display("[TB] FAIL arben_directed c=%0d: got winc=%b gv=%b id=%0d",
                        c, bus.winc, bus.gnt_valid, bus.gnt_id);
            end
         end
`ifdef FIFO_ARB_STATS_EN
         if (c == 7) begin
            total++;
            if ({beatCount, stallCount} !== {16'd0, 16'd0, 16'd0, 16'd2, 16'd0}) begin
               bad++;
               $display("[TB] FAIL arben_stats: got %h expected beat0=2 others 0", {beatCount, stallCount});
            end
         end
`endif
         endCycle();
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      doReset();
      gapPct = 30; randData = 1;
      for (int i = 0; i < NREQ; i++) begin
         r = $urandom;
         srcLeft[i] = 200; srcNext[i] = r[DSIZE-1:0];
      end
      for (int c = 0; c < 600; c++) begin
         oneCycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0);
         total++;
         if (actVec !== expVec) begin
            bad++;
            $display("[TB] FAIL random_model c=%0d: got %h expected %h", c, actVec, expVec);
         end
         endCycle();
      end
      for (int i = 0; i < NREQ; i++) begin
         total++;
         if (accepted[i] != mTot[i]) begin
            bad++;
            $display("[TB] FAIL random_accepts req=%0d: got %0d expected %0d", i, accepted[i], mTot[i]);
         end
`ifdef FIFO_ARB_STATS_EN
         total++;
         if (beatCount[i*16 +: 16] !== 16'(mTot[i])) begin
            bad++;
            $display("[TB] FAIL random_beat_count req=%0d: got %0d expected %0d",
                     i, beatCount[i*16 +: 16], mTot[i]);
         end
`endif
      end
`ifdef FIFO_ARB_STATS_EN
      total++;
      if (stallCount !== 16'(mStall)) begin
         bad++;
         $display("[TB] FAIL random_stall_count: got %0d expected %0d", stallCount, mStall);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_valid();
      test_wfull_stall();
      test_drop_valid();
      test_reset_mid();
      test_arb_en_drop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side scheduler for the dual-clock FIFO. Shares the single FIFO write port (wdata/winc/wfull) among NREQ requesters in the wclk domain, using round-robin arbitration with bounded bursts. Sits between the producer blocks and the FIFO write interface. Never issues winc while wfull is high.

Parameters:
NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ) is a derived localparam
DSIZE, 8, data width, matches FIFO DSIZE
MAX_BURST, 4, max beats per grant before rotation (>=1)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  reset, asynchronous, active-low
arb_en  in  1  arbitration enable
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*DSIZE  flattened; requester i occupies bits [i*DSIZE +: DSIZE]
req_ready  out  NREQ  per-requester accept
wfull  in  1  FIFO full (registered, wclk domain)
winc  out  1  FIFO write strobe
wdata  out  DSIZE  FIFO write data
gnt_valid  out  1  a grant is held (state BURST)
gnt_id  out  IDW  index of granted requester

Behaviour:
- Reset (asynchronous, wrst_n low): state IDLE, gnt_id=0, gnt_valid=0, rr_ptr=0, beat_cnt=0. Outputs winc=0, req_ready=0, wdata=0.
- Reset mid-burst aborts the burst immediately. No further winc.
- States: IDLE, BURST. Registers: gnt_id, rr_ptr (IDW), beat_cnt (clog2(MAX_BURST)+1 bits).
- IDLE:
  - winc=0, req_ready=0.
  - If arb_en=1 and |req_valid: choose first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Load gnt_id=i, clear beat_cnt, next state BURST.
  - Arbitration takes one cycle; no write occurs in IDLE.
- BURST (gnt_valid=1):
  - Combinational: wdata = req_data slice[gnt_id]; req_ready[gnt_id] = ~wfull, all other req_ready bits 0; winc = req_valid[gnt_id] & ~wfull.
  - A beat is a cycle with winc=1. Each beat increments beat_cnt.
  - Exit to IDLE at the clock edge when any of these holds:
    - (a) beat and beat_cnt==MAX_BURST-1;
    - (b) req_valid[gnt_id]=0 (no write that cycle);
    - (c) arb_en=0 (a beat in that same cycle is still allowed).
  - On exit: rr_ptr = (gnt_id+1) mod NREQ.
- wfull=1 in BURST: winc=0, ready=0, beat_cnt held, grant held. No timeout; the burst resumes when wfull falls.
- Requester rule: req_data[i] must stay stable while req_valid[i] & ~req_ready[i]. The arbiter relies on this.
- Back-to-back bursts: there is exactly one IDLE bubble cycle between consecutive grants.
- MAX_BURST=1 gives per-beat round-robin, one beat per 2 cycles.
- Non-granted requests are ignored until rotation. Round-robin with a bounded burst guarantees every valid requester a grant within NREQ*(MAX_BURST+1) unstalled cycles.

Optional Feature:
FIFO_ARB_STATS_EN:
- Defined: adds output beat_count, NREQ*16 bits, flattened. Each requester has a 16-bit counter of accepted beats; it saturates at 16'hFFFF and resets to 0 on wrst_n. Also adds output stall_count, 16 bits, saturating: counts BURST cycles with wfull=1 and req_valid[gnt_id]=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester: req_valid[2]=1 with data 8'h01,02,03, then valid drops. Expect gnt_id=2 one cycle after valid, winc on 3 consecutive cycles with wdata 01,02,03, then IDLE; rr_ptr=3.
- All 4 requesters continuously valid, MAX_BURST=4. Expect grants 0,1,2,3,0 in order, 4 beats each, one bubble cycle between grants, no winc in the bubble.
- wfull forced high for 3 cycles after the 2nd beat of requester 1. Expect winc=0 and req_ready=0 for those 3 cycles, gnt_id stays 1, then beats 3-4 complete; total 4 beats, no extra write.
- Requester 0 drops valid after 2 beats while requester 3 is valid. Expect release after 2 beats, IDLE for 1 cycle, then gnt_id=3.
- wrst_n pulsed low mid-burst. Expect winc, gnt_valid and req_ready all 0 immediately (asynchronous); after release, arbitration starts from requester 0.
- arb_en dropped during a burst. Expect the current-cycle beat completes, then IDLE; no new grant while arb_en=0. With FIFO_ARB_STATS_EN, beat_count matches the beats each requester had accepted before arb_en dropped.
